// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the FP multiplier issue controller.
package fp_mul_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    typedef struct packed {
        logic nan;
        logic inf;
        logic ovf;
        logic unf;
    } fp_flags_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } fp_opnd_t;

    localparam logic [31:0] FP_QNAN = 32'h7FC00000;

endpackage

// File: rtl/fp_operand_fifo.sv
// Operand-pair FIFO. Occupancy is a separate counter so full/empty never alias.
module fp_operand_fifo #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [63:0]   din_i,
    input  logic          pop_i,
    output logic [63:0]   dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    // A push while full is refused even if a pop frees a slot this cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/fp_mul_issue_ctrl.sv
// Issues buffered operand pairs to multiplier32FP one at a time and captures
// the product/flags into a valid/ready output slot, with a completion watchdog.
module fp_mul_issue_ctrl
    import fp_mul_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [31:0]              in_a_i,
    input  logic [31:0]              in_b_i,
    output logic                     mul_start_o,
    output logic [31:0]              mul_a_o,
    output logic [31:0]              mul_b_o,
    input  logic                     mul_done_i,
    input  logic [31:0]              mul_product_i,
    input  logic                     mul_nan_i,
    input  logic                     mul_inf_i,
    input  logic                     mul_ovf_i,
    input  logic                     mul_unf_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [31:0]              out_product_o,
    output logic [3:0]               out_flags_o,
    output logic                     timeout_o,
    output logic [$clog2(DEPTH):0]   pending_o
);

    localparam int WW = $clog2(TIMEOUT);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic        start_q, start_d;
    logic [WW-1:0] wd_q, wd_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] prod_q, prod_d;
    fp_flags_t   flags_q, flags_d;
    logic        timeout_q, timeout_d;

    logic        fifo_full, fifo_empty, pop;
    fp_opnd_t    head;
    logic        cap;
    logic [31:0] cap_prod;
    fp_flags_t   cap_flags;

    fp_operand_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (in_valid_i),
        .din_i   ({in_a_i, in_b_i}),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (pending_o)
    );

    always_comb begin
        state_d     = state_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        start_d     = 1'b0;
        wd_d        = wd_q;
        pop         = 1'b0;
        timeout_d   = timeout_q;
        cap         = 1'b0;
        cap_prod    = mul_product_i;
        cap_flags   = '{nan: mul_nan_i, inf: mul_inf_i, ovf: mul_ovf_i, unf: mul_unf_i};
        out_valid_d = out_valid_q && !out_ready_i;
        prod_d      = prod_q;
        flags_d     = flags_q;

        unique case (state_q)
            IDLE: begin
                // Holding off while the output slot is occupied guarantees no result is dropped.
                if (!fifo_empty && !out_valid_q) begin
                    pop     = 1'b1;
                    mul_a_d = head.a;
                    mul_b_d = head.b;
                    start_d = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                wd_d = '0;
                if (mul_done_i) begin
                    cap     = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mul_done_i) begin
                    cap     = 1'b1;
                    state_d = IDLE;
                end else if (wd_q == WD_LAST) begin
                    cap       = 1'b1;
                    cap_prod  = FP_QNAN;
                    cap_flags = '{nan: 1'b1, inf: 1'b0, ovf: 1'b0, unf: 1'b0};
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (cap) begin
            out_valid_d = 1'b1;
            prod_d      = cap_prod;
            flags_d     = cap_flags;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            start_q     <= 1'b0;
            wd_q        <= '0;
            out_valid_q <= 1'b0;
            prod_q      <= '0;
            flags_q     <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            start_q     <= start_d;
            wd_q        <= wd_d;
            out_valid_q <= out_valid_d;
            prod_q      <= prod_d;
            flags_q     <= flags_d;
            timeout_q   <= timeout_d;
        end
    end

    assign in_ready_o    = !fifo_full;
    assign mul_start_o   = start_q;
    assign mul_a_o       = mul_a_q;
    assign mul_b_o       = mul_b_q;
    assign out_valid_o   = out_valid_q;
    assign out_product_o = prod_q;
    assign out_flags_o   = flags_q;
    assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_fp_mul_issue_ctrl.sv
// Directed bench for fp_mul_issue_ctrl with a fixed-latency multiplier model.
module tb_fp_mul_issue_ctrl;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid_i, in_ready_o;
    logic [31:0] in_a_i, in_b_i;
    logic        mul_start_o;
    logic [31:0] mul_a_o, mul_b_o;
    logic        mul_done_i;
    logic [31:0] mul_product_i;
    logic        mul_nan_i, mul_inf_i, mul_ovf_i, mul_unf_i;
    logic        out_valid_o, out_ready_i;
    logic [31:0] out_product_o;
    logic [3:0]  out_flags_o;
    logic        timeout_o;
    logic [$clog2(DEPTH):0] pending_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fp_mul_issue_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_a_i(in_a_i), .in_b_i(in_b_i),
        .mul_start_o(mul_start_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
        .mul_done_i(mul_done_i), .mul_product_i(mul_product_i),
        .mul_nan_i(mul_nan_i), .mul_inf_i(mul_inf_i),
        .mul_ovf_i(mul_ovf_i), .mul_unf_i(mul_unf_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_product_o(out_product_o), .out_flags_o(out_flags_o),
        .timeout_o(timeout_o), .pending_o(pending_o)
    );

    // Multiplier model: product table plus done pulse 'lat' cycles after start.
    int   lat;
    logic mdl_clr;
    logic mdl_done, mdl_busy;
    int   mdl_cnt;

    function automatic logic [35:0] mdl_res(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h3F800000_40000000: return {32'h40000000, 4'b0000};
            64'h7F800000_00000000: return {32'h7FC00000, 4'b1000};
            64'h7F7FFFFF_7F7FFFFF: return {32'h7F800000, 4'b0110};
            64'h40400000_40400000: return {32'h41100000, 4'b0000};
            default:               return {32'hDEADBEEF, 4'b0001};
        endcase
    endfunction

    always @(posedge clk) begin
        if (mdl_clr) begin
            mdl_done <= 1'b0; mdl_busy <= 1'b0; mdl_cnt <= 0;
        end else if (mul_start_o && lat > 0) begin
            mdl_busy <= (lat > 1); mdl_cnt <= 1; mdl_done <= (lat == 1);
        end else if (mdl_busy) begin
            mdl_cnt  <= mdl_cnt + 1;
            mdl_done <= (mdl_cnt + 1 == lat);
            mdl_busy <= (mdl_cnt + 1 != lat);
        end else begin
            mdl_done <= 1'b0;
        end
    end

    assign mul_done_i = (lat == 0) ? mul_start_o : mdl_done;
    assign {mul_product_i, mul_nan_i, mul_inf_i, mul_ovf_i, mul_unf_i} = mdl_res(mul_a_o, mul_b_o);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic [31:0] a, input logic [31:0] b);
        int k = 0;
        in_valid_i = 1'b1; in_a_i = a; in_b_i = b;
        while (!in_ready_o && k < 50) begin @(negedge clk); k++; end
        if (k == 50) chk("push_stall", 1'b0, 1'b1);
        @(negedge clk);
        in_valid_i = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [31:0] p, input logic [3:0] f);
        int k = 0;
        while (!out_valid_o && k < 200) begin @(negedge clk); k++; end
        chk({tag, "_valid"}, out_valid_o, 1'b1);
        chk({tag, "_prod"}, out_product_o, p);
        chk({tag, "_flags"}, out_flags_o, f);
        out_ready_i = 1'b1;
        @(negedge clk);
        out_ready_i = 1'b0;
    endtask

    initial begin
        int acc, n, k, extra;
        rst_n = 1'b0; mdl_clr = 1'b1; lat = 5;
        in_valid_i = 1'b0; in_a_i = '0; in_b_i = '0; out_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        mdl_clr = 1'b0;

        // Reset state
        chk("rst_in_ready", in_ready_o, 1'b1);
        chk("rst_pending", pending_o, 0);
        chk("rst_start", mul_start_o, 1'b0);
        chk("rst_mul_a", mul_a_o, 0);
        chk("rst_out_valid", out_valid_o, 1'b0);
        chk("rst_prod", out_product_o, 0);
        chk("rst_flags", out_flags_o, 0);
        chk("rst_timeout", timeout_o, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single op: issue latency and result latency
        push(32'h3F800000, 32'h40000000);
        chk("s1_pend_c1", pending_o, 1);
        chk("s1_nostart_c1", mul_start_o, 1'b0);
        @(negedge clk);
        chk("s1_start_c2", mul_start_o, 1'b1);
        chk("s1_mul_a", mul_a_o, 32'h3F800000);
        chk("s1_mul_b", mul_b_o, 32'h40000000);
        chk("s1_pend_c2", pending_o, 0);
        k = 0;
        while (!mul_done_i && k < 20) begin @(negedge clk); k++; end
        chk("s1_valid_at_done", out_valid_o, 1'b0);
        @(negedge clk);
        chk("s1_valid", out_valid_o, 1'b1);
        chk("s1_prod", out_product_o, 32'h40000000);
        chk("s1_flags", out_flags_o, 4'b0000);
        out_ready_i = 1'b1;
        @(negedge clk);
        out_ready_i = 1'b0;
        chk("s1_valid_clr", out_valid_o, 1'b0);

        // Exception flag passthrough
        push(32'h7F800000, 32'h00000000);
        wait_result("exc_nan", 32'h7FC00000, 4'b1000);
        push(32'h7F7FFFFF, 32'h7F7FFFFF);
        wait_result("exc_ovf", 32'h7F800000, 4'b0110);

        // Fill with output blocked: 4 queued + 1 issued
        lat = 2; acc = 0;
        in_a_i = 32'h40400000; in_b_i = 32'h40400000; in_valid_i = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (in_ready_o) acc++;
            if (acc == 6) in_valid_i = 1'b0;
            @(negedge clk);
        end
        in_valid_i = 1'b0;
        chk("fill_accepts", acc, 5);
        chk("fill_ready", in_ready_o, 1'b0);
        chk("fill_pending", pending_o, 4);
        chk("fill_valid", out_valid_o, 1'b1);
        out_ready_i = 1'b1;
        for (int r = 0; r < 5; r++) begin
            k = 0;
            while (!out_valid_o && k < 50) begin @(negedge clk); k++; end
            chk("drain_prod", out_product_o, 32'h41100000);
            @(negedge clk);
            if (r < 4) begin
                chk("b2b_nostart", mul_start_o, 1'b0);
                @(negedge clk);
                chk("b2b_start", mul_start_o, 1'b1);
                chk("b2b_pending", pending_o, 3 - r);
            end
        end
        out_ready_i = 1'b0;
        chk("drain_pending", pending_o, 0);
        chk("drain_ready", in_ready_o, 1'b1);

        // Watchdog: done arrives only long after the timeout
        lat = 80;
        push(32'h3F800000, 32'h40000000);
        k = 0;
        while (!mul_start_o && k < 10) begin @(negedge clk); k++; end
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid_o && n < 200);
        chk("wd_cycles", n, TIMEOUT + 1);
        chk("wd_prod", out_product_o, 32'h7FC00000);
        chk("wd_flags", out_flags_o, 4'b1000);
        chk("wd_timeout", timeout_o, 1'b1);
        out_ready_i = 1'b1;
        @(negedge clk);
        out_ready_i = 1'b0;
        extra = 0;
        for (int c = 0; c < 25; c++) begin
            if (out_valid_o || mul_start_o) extra++;
            @(negedge clk);
        end
        chk("wd_late_done", extra, 0);
        chk("wd_sticky", timeout_o, 1'b1);

        // Reset while in WAIT with three entries queued
        lat = 10;
        push(32'h40400000, 32'h40400000);
        push(32'h40400000, 32'h40400000);
        push(32'h40400000, 32'h40400000);
        push(32'h40400000, 32'h40400000);
        chk("mr_pending", pending_o, 3);
        rst_n = 1'b0;
        #1;
        chk("mr_pending_rst", pending_o, 0);
        chk("mr_ready_rst", in_ready_o, 1'b1);
        chk("mr_timeout_rst", timeout_o, 1'b0);
        chk("mr_start_rst", mul_start_o, 1'b0);
        chk("mr_mul_a_rst", mul_a_o, 0);
        chk("mr_valid_rst", out_valid_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        for (int c = 0; c < 15; c++) begin
            if (out_valid_o || mul_start_o) extra++;
            @(negedge clk);
        end
        chk("mr_done_ignored", extra, 0);

        // Zero-latency multiplier: done in ISSUE
        lat = 0;
        push(32'h3F800000, 32'h40000000);
        @(negedge clk);
        chk("zi_start", mul_start_o, 1'b1);
        chk("zi_valid_c2", out_valid_o, 1'b0);
        @(negedge clk);
        chk("zi_valid_c3", out_valid_o, 1'b1);
        chk("zi_prod", out_product_o, 32'h40000000);
        chk("zi_start_c3", mul_start_o, 1'b0);
        out_ready_i = 1'b1;
        @(negedge clk);
        out_ready_i = 1'b0;
        lat = 3;
        push(32'h40400000, 32'h40400000);
        wait_result("zi_next", 32'h41100000, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
